// File: rtl/symbol_sequencer.sv
// Memory-game sequencer: draws an LFSR symbol sequence, plays it frame-aligned
// to the VGA display stage, then checks the player's button answers.
module symbol_sequencer #(
  parameter int unsigned SEQ_LEN     = 4,
  parameter int unsigned SHOW_FRAMES = 60,
  parameter int unsigned GAP_FRAMES  = 15,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       dclk,
  input  logic       clr_n,
  input  logic       vsync,
  input  logic       start,
  input  logic [2:0] btn,
  output logic [1:0] symbol,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam logic [2:0] LAST_IDX  = 3'(SEQ_LEN - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_FRAMES - 1);
  localparam logic [7:0] SHOW_LAST = 8'(SHOW_FRAMES - 1);

  localparam logic [1:0] SYM_BLANK = 2'd0;
  localparam logic [1:0] SYM_LOSE  = 2'd2;
  localparam logic [1:0] SYM_WIN   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_SHOW, S_INPUT, S_WIN, S_LOSE
  } state_t;

  state_t          r_state;
  logic [7:0]      r_lfsr;
  logic [2:0]      r_idx;
  logic [7:0]      r_fcnt;
  logic            r_vs_d;
  logic [7:0][1:0] r_seq;
  logic [1:0]      r_symbol;
  logic            r_busy;
  logic            r_win;
  logic            r_lose;

  state_t     w_next_state;
  logic [2:0] w_next_idx;
  logic [7:0] w_next_fcnt;
  logic       w_load_en;
  logic       w_frame_tick;
  logic [2:0] w_exp_btn;
  logic [1:0] w_entry;
  logic [1:0] w_next_symbol;

  // One cycle per frame, while vsync is first seen low
  assign w_frame_tick = r_vs_d & ~vsync;

  // Entry 0 would be the blank field, so it is folded onto symbol 1
  assign w_entry = (r_lfsr[1:0] == 2'd0) ? 2'd1 : r_lfsr[1:0];

  // Button that answers the current entry: btn[k] stands for symbol k+1
  always_comb begin
    w_exp_btn = 3'b000;
    case (r_seq[r_idx])
      2'd1:    w_exp_btn = 3'b001;
      2'd2:    w_exp_btn = 3'b010;
      2'd3:    w_exp_btn = 3'b100;
      default: w_exp_btn = 3'b000;
    endcase
  end

  // Next-state and counter logic
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_fcnt  = r_fcnt;
    w_load_en    = 1'b0;
    case (r_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          w_next_state = S_LOAD;
          w_next_idx   = 3'd0;
          w_next_fcnt  = 8'd0;
        end
      end
      S_LOAD: begin
        w_load_en = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_next_state = S_GAP;
          w_next_idx   = 3'd0;
        end else begin
          w_next_idx = r_idx + 3'd1;
        end
      end
      S_GAP: begin
        if (w_frame_tick) begin
          if (r_fcnt == GAP_LAST) begin
            w_next_state = S_SHOW;
            w_next_fcnt  = 8'd0;
          end else begin
            w_next_fcnt = r_fcnt + 8'd1;
          end
        end
      end
      S_SHOW: begin
        if (w_frame_tick) begin
          if (r_fcnt == SHOW_LAST) begin
            w_next_fcnt = 8'd0;
            if (r_idx == LAST_IDX) begin
              w_next_state = S_INPUT;
              w_next_idx   = 3'd0;
            end else begin
              w_next_state = S_GAP;
              w_next_idx   = r_idx + 3'd1;
            end
          end else begin
            w_next_fcnt = r_fcnt + 8'd1;
          end
        end
      end
      S_INPUT: begin
        if (btn != 3'b000) begin
          if (btn == w_exp_btn) begin
            if (r_idx == LAST_IDX) begin
              w_next_state = S_WIN;
            end else begin
              w_next_idx = r_idx + 3'd1;
            end
          end else begin
            w_next_state = S_LOSE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Symbol implied by the state being entered
  always_comb begin
    w_next_symbol = SYM_BLANK;
    case (w_next_state)
      S_SHOW:  w_next_symbol = r_seq[w_next_idx];
      S_WIN:   w_next_symbol = SYM_WIN;
      S_LOSE:  w_next_symbol = SYM_LOSE;
      default: w_next_symbol = SYM_BLANK;
    endcase
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= S_IDLE;
      r_lfsr   <= LFSR_SEED;
      r_idx    <= 3'd0;
      r_fcnt   <= 8'd0;
      r_vs_d   <= 1'b1;
      r_seq    <= '0;
      r_symbol <= SYM_BLANK;
      r_busy   <= 1'b0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_fcnt  <= w_next_fcnt;
      r_vs_d  <= vsync;
      if (w_load_en) begin
        r_seq[r_idx] <= w_entry;
        r_lfsr       <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
      // Symbol only moves during vertical blanking
      if (w_frame_tick) begin
        r_symbol <= w_next_symbol;
      end
      r_busy <= (w_next_state == S_LOAD) || (w_next_state == S_GAP) ||
                (w_next_state == S_SHOW) || (w_next_state == S_INPUT);
      r_win  <= (w_next_state == S_WIN);
      r_lose <= (w_next_state == S_LOSE);
    end
  end

  assign symbol = r_symbol;
  assign busy   = r_busy;
  assign win    = r_win;
  assign lose   = r_lose;

endmodule
